// File: rtl/display_frame_sequencer.sv
// Once per video frame: snapshot game state into shadow registers at vblank start,
// then step the sprite animation and prompt-blink counters from that snapshot.
module display_frame_sequencer #(
  parameter int V_ACTIVE    = 480,
  parameter int ANIM_DIV    = 4,
  parameter int PIKA_FRAMES = 5,
  parameter int BALL_FRAMES = 8,
  parameter int BLINK_DIV   = 30,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_y,
  input  logic        snap_ack,
  input  logic [11:0] player_x_in,
  input  logic [11:0] player_y_in,
  input  logic [11:0] computer_x_in,
  input  logic [11:0] computer_y_in,
  input  logic [11:0] ball_x_in,
  input  logic [11:0] ball_y_in,
  input  logic [2:0]  player_score_in,
  input  logic [2:0]  computer_score_in,
  input  logic [1:0]  game_state_in,
  output logic        snap_req,
  output logic [11:0] player_x,
  output logic [11:0] player_y,
  output logic [11:0] computer_x,
  output logic [11:0] computer_y,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [2:0]  player_score,
  output logic [2:0]  computer_score,
  output logic [1:0]  game_state,
  output logic [2:0]  pika_frame,
  output logic [2:0]  ball_frame,
  output logic        prompt_blink,
  output logic        stale
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    PIKA_LAST  = 3'(PIKA_FRAMES - 1);
  localparam logic [2:0]    BALL_LAST  = 3'(BALL_FRAMES - 1);

  typedef enum logic [1:0] {ACTIVE, REQ, COMMIT, WAIT_VIS} state_t;

  state_t          state, next_state;
  logic            vb_prev;
  logic            vb_line;
  logic            vb_start;
  logic            line_zero;
  logic            give_up;
  logic [TW-1:0]   to_cnt;
  logic [AW-1:0]   anim_cnt;
  logic [BW-1:0]   blink_cnt;
  logic [1:0]      game_state_prev;
  logic            gs_changed;

  assign vb_line    = (pixel_y == 10'(V_ACTIVE));
  assign vb_start   = vb_line && !vb_prev;
  assign line_zero  = (pixel_y == 10'd0);
  assign give_up    = (to_cnt == TO_LAST) || line_zero;
  assign gs_changed = (game_state != game_state_prev);

  always_comb begin
    next_state = state;
    case (state)
      ACTIVE:   if (vb_start) next_state = REQ;
      REQ:      if (snap_ack || give_up) next_state = COMMIT;
      COMMIT:   next_state = WAIT_VIS;
      WAIT_VIS: if (line_zero) next_state = ACTIVE;
      default:  next_state = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ACTIVE;
      snap_req        <= 1'b0;
      vb_prev         <= 1'b0;
      to_cnt          <= '0;
      anim_cnt        <= '0;
      blink_cnt       <= '0;
      game_state_prev <= 2'd0;
      player_x        <= '0;
      player_y        <= '0;
      computer_x      <= '0;
      computer_y      <= '0;
      ball_x          <= '0;
      ball_y          <= '0;
      player_score    <= '0;
      computer_score  <= '0;
      game_state      <= '0;
      pika_frame      <= '0;
      ball_frame      <= '0;
      prompt_blink    <= 1'b1;
      stale           <= 1'b0;
    end else begin
      state    <= next_state;
      snap_req <= (next_state == REQ);
      vb_prev  <= vb_line;

      // Saturating counter: a stuck request can never wrap back to an early abort point.
      if (state == ACTIVE && vb_start) begin
        to_cnt <= '0;
      end else if (state == REQ && to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state == REQ) begin
        if (snap_ack) begin
          player_x       <= player_x_in;
          player_y       <= player_y_in;
          computer_x     <= computer_x_in;
          computer_y     <= computer_y_in;
          ball_x         <= ball_x_in;
          ball_y         <= ball_y_in;
          player_score   <= player_score_in;
          computer_score <= computer_score_in;
          game_state     <= game_state_in;
          stale          <= 1'b0;
        end else if (give_up) begin
          stale <= 1'b1;
        end
      end

      // Frame tick sees the shadow game_state already updated by this frame's latch.
      if (state == COMMIT) begin
        game_state_prev <= game_state;

        if (anim_cnt == ANIM_LAST) begin
          anim_cnt <= '0;
          if (game_state != 2'd3) begin
            pika_frame <= (pika_frame == PIKA_LAST) ? 3'd0 : pika_frame + 3'd1;
            ball_frame <= (ball_frame == BALL_LAST) ? 3'd0 : ball_frame + 3'd1;
          end
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end

        if (gs_changed) begin
          prompt_blink <= 1'b1;
          blink_cnt    <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_cnt    <= '0;
          prompt_blink <= ~prompt_blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed bench for display_frame_sequencer: a frame-level model pushes expected
// shadow/animation state per frame, popped and compared once the commit completes.
module tb_display_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_y = '0;
  logic        snap_ack = 1'b0;
  logic [11:0] player_x_in = '0, player_y_in = '0, computer_x_in = '0;
  logic [11:0] computer_y_in = '0, ball_x_in = '0, ball_y_in = '0;
  logic [2:0]  player_score_in = '0, computer_score_in = '0;
  logic [1:0]  game_state_in = '0;
  logic        snap_req;
  logic [11:0] player_x, player_y, computer_x, computer_y, ball_x, ball_y;
  logic [2:0]  player_score, computer_score;
  logic [1:0]  game_state;
  logic [2:0]  pika_frame, ball_frame;
  logic        prompt_blink, stale;

  always #5 clk = ~clk;

  display_frame_sequencer dut (
    .clk(clk), .reset(reset), .pixel_y(pixel_y), .snap_ack(snap_ack),
    .player_x_in(player_x_in), .player_y_in(player_y_in),
    .computer_x_in(computer_x_in), .computer_y_in(computer_y_in),
    .ball_x_in(ball_x_in), .ball_y_in(ball_y_in),
    .player_score_in(player_score_in), .computer_score_in(computer_score_in),
    .game_state_in(game_state_in), .snap_req(snap_req),
    .player_x(player_x), .player_y(player_y),
    .computer_x(computer_x), .computer_y(computer_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .player_score(player_score), .computer_score(computer_score),
    .game_state(game_state), .pika_frame(pika_frame), .ball_frame(ball_frame),
    .prompt_blink(prompt_blink), .stale(stale)
  );

  typedef struct {
    logic [11:0] bx, px;
    logic [2:0]  ps, cs;
    logic [1:0]  gs;
    logic        stale;
    logic [2:0]  pika, ball;
    logic        blink;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [11:0] m_bx, m_px;
  logic [2:0]  m_ps, m_cs, m_pika, m_ball;
  logic [1:0]  m_gs, m_gs_last;
  logic        m_stale, m_blink;
  int          m_anim, m_bcnt;
  logic [2:0]  pika_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = '0; m_px = '0; m_ps = '0; m_cs = '0; m_gs = '0; m_gs_last = '0;
    m_stale = 1'b0; m_pika = '0; m_ball = '0; m_blink = 1'b1;
    m_anim = 0; m_bcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_frame(input bit acked, input logic [11:0] bx,
                             input logic [2:0] ps, input logic [1:0] gs);
    exp_t e;
    bit changed;
    if (acked) begin
      m_bx = bx; m_px = bx + 12'd1; m_ps = ps; m_cs = ps ^ 3'd1; m_gs = gs; m_stale = 1'b0;
    end else begin
      m_stale = 1'b1;
    end
    changed = (m_gs != m_gs_last);
    m_gs_last = m_gs;
    if (m_anim == 3) begin
      m_anim = 0;
      if (m_gs != 2'd3) begin
        m_pika = (m_pika == 3'd4) ? 3'd0 : m_pika + 3'd1;
        m_ball = (m_ball == 3'd7) ? 3'd0 : m_ball + 3'd1;
      end
    end else begin
      m_anim++;
    end
    if (changed) begin
      m_blink = 1'b1; m_bcnt = 0;
    end else if (m_bcnt == 29) begin
      m_bcnt = 0; m_blink = ~m_blink;
    end else begin
      m_bcnt++;
    end
    e.bx = m_bx; e.px = m_px; e.ps = m_ps; e.cs = m_cs; e.gs = m_gs;
    e.stale = m_stale; e.pika = m_pika; e.ball = m_ball; e.blink = m_blink;
    exp_q.push_back(e);
  endtask

  task automatic compare_frame();
    exp_t e;
    chk("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("ball_x", 32'(ball_x), 32'(e.bx));
    chk("player_x", 32'(player_x), 32'(e.px));
    chk("player_score", 32'(player_score), 32'(e.ps));
    chk("computer_score", 32'(computer_score), 32'(e.cs));
    chk("game_state", 32'(game_state), 32'(e.gs));
    chk("stale", 32'(stale), 32'(e.stale));
    chk("pika_frame", 32'(pika_frame), 32'(e.pika));
    chk("ball_frame", 32'(ball_frame), 32'(e.ball));
    chk("prompt_blink", 32'(prompt_blink), 32'(e.blink));
  endtask

  task automatic drive_inputs(input logic [11:0] bx, input logic [2:0] ps, input logic [1:0] gs);
    ball_x_in = bx; player_x_in = bx + 12'd1; player_y_in = bx + 12'd2;
    computer_x_in = bx + 12'd3; computer_y_in = bx + 12'd4; ball_y_in = bx + 12'd5;
    player_score_in = ps; computer_score_in = ps ^ 3'd1; game_state_in = gs;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(snap_req), 32'd0);
    chk({tag, "_bx"}, 32'(ball_x), 32'd0);
    chk({tag, "_ps"}, 32'(player_score), 32'd0);
    chk({tag, "_gs"}, 32'(game_state), 32'd0);
    chk({tag, "_pika"}, 32'(pika_frame), 32'd0);
    chk({tag, "_ball"}, 32'(ball_frame), 32'd0);
    chk({tag, "_blink"}, 32'(prompt_blink), 32'd1);
    chk({tag, "_stale"}, 32'(stale), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; snap_ack = 1'b0; pixel_y = '0;
    step(); step();
    reset = 1'b0;
    model_reset();
  endtask

  // mode 0: ack, 1: abort at line 0, 2: timeout, 3: ack on the timeout cycle
  task automatic run_frame(input int mode, input logic [11:0] bx,
                           input logic [2:0] ps, input logic [1:0] gs);
    int n;
    pixel_y = 10'd0; repeat (3) step();
    pixel_y = 10'd200; drive_inputs(bx, ps, gs); step();
    chk("idle_req", 32'(snap_req), 32'd0);
    pixel_y = 10'd480; step();
    chk("req_rise", 32'(snap_req), 32'd1);
    pixel_y = 10'd481;
    model_frame(mode == 0 || mode == 3, bx, ps, gs);
    if (mode == 0) begin
      step(); step();
      snap_ack = 1'b1; step(); snap_ack = 1'b0;
      chk("ack_latency_bx", 32'(ball_x), 32'(bx));
      chk("ack_req_drop", 32'(snap_req), 32'd0);
    end else if (mode == 1) begin
      step(); pixel_y = 10'd0; step();
    end else begin
      pixel_y = 10'd490;
      n = 0;
      while (snap_req === 1'b1 && n < 1100) begin
        n++;
        if (mode == 3 && n == 1024) snap_ack = 1'b1;
        step();
        snap_ack = 1'b0;
      end
      chk("req_len", 32'(n), 32'd1024);
    end
    step();
    compare_frame();
  endtask

  task automatic sweep_frame(input bit first);
    int rises;
    logic prev;
    rises = 0;
    prev = snap_req;
    for (int y = 0; y < 525; y++) begin
      pixel_y = 10'(y);
      snap_ack = (y == 483);
      step();
      if (y == 480) chk("sweep_req_rise", 32'(snap_req), 32'd1);
      if (first && y == 482) begin
        chk("pre_ack_bx", 32'(ball_x), 32'd0);
        chk("pre_ack_pika", 32'(pika_frame), 32'd0);
        chk("pre_ack_blink", 32'(prompt_blink), 32'd1);
        chk("pre_ack_stale", 32'(stale), 32'd0);
      end
      if (snap_req && !prev) rises++;
      prev = snap_req;
    end
    snap_ack = 1'b0;
    chk("sweep_rises", 32'(rises), 32'd1);
  endtask

  initial begin
    model_reset();
    drive_inputs(12'd0, 3'd0, 2'd0);
    do_reset();
    check_reset_vals("reset");

    sweep_frame(1'b1);
    sweep_frame(1'b0);

    do_reset();
    run_frame(0, 12'd100, 3'd3, 2'd0);
    chk("t2_player_score", 32'(player_score), 32'd3);
    chk("t2_stale", 32'(stale), 32'd0);

    run_frame(2, 12'd200, 3'd1, 2'd0);
    chk("t3_shadow_held", 32'(ball_x), 32'd100);
    chk("t3_stale", 32'(stale), 32'd1);
    run_frame(1, 12'd300, 3'd2, 2'd0);
    run_frame(1, 12'd301, 3'd2, 2'd0);
    chk("t3_pika_4th_frame", 32'(pika_frame), 32'd1);

    run_frame(0, 12'd10, 3'd1, 2'd1);
    chk("t5_blink_forced", 32'(prompt_blink), 32'd1);
    for (int i = 0; i < 62; i++) begin
      run_frame(0, 12'(20 + i), 3'd2, 2'd1);
      if (i == 28) chk("t5_blink_before_toggle", 32'(prompt_blink), 32'd1);
      if (i == 29) chk("t5_blink_toggle1", 32'(prompt_blink), 32'd0);
      if (i == 59) chk("t5_blink_toggle2", 32'(prompt_blink), 32'd1);
    end

    pixel_y = 10'd0; step(); step();
    pixel_y = 10'd100;
    drive_inputs(12'd999, 3'd7, 2'd3);
    snap_ack = 1'b1; repeat (3) step(); snap_ack = 1'b0;
    chk("stray_ack_bx", 32'(ball_x), 32'(m_bx));
    chk("stray_ack_gs", 32'(game_state), 32'(m_gs));
    chk("stray_ack_req", 32'(snap_req), 32'd0);
    chk("stray_ack_pika", 32'(pika_frame), 32'(m_pika));
    chk("stray_ack_stale", 32'(stale), 32'(m_stale));

    do_reset();
    for (int k = 1; k <= 20; k++) begin
      run_frame(0, 12'(k), 3'd0, 2'd1);
      if (k % 4 == 0) chk("t4_pika_seq", 32'(pika_frame), 32'(pika_seq[k/4 - 1]));
      if (k == 16) chk("t4_ball_reaches4", 32'(ball_frame), 32'd4);
    end
    for (int k = 0; k < 8; k++) run_frame(0, 12'd50, 3'd0, 2'd3);
    chk("t4_pika_hold", 32'(pika_frame), 32'd0);
    chk("t4_ball_hold", 32'(ball_frame), 32'd5);

    pixel_y = 10'd0; repeat (3) step();
    pixel_y = 10'd480; step();
    chk("t6_in_req", 32'(snap_req), 32'd1);
    pixel_y = 10'd481;
    drive_inputs(12'd777, 3'd5, 2'd2);
    step();
    reset = 1'b1; snap_ack = 1'b1; step();
    reset = 1'b0; snap_ack = 1'b0;
    check_reset_vals("t6_reset_mid_req");
    model_reset();

    run_frame(3, 12'd55, 3'd6, 2'd1);
    chk("t6_ack_on_timeout_stale", 32'(stale), 32'd0);
    chk("t6_ack_on_timeout_bx", 32'(ball_x), 32'd55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
